seq_cmp_mag: RTL

Parametrised bit-serial magnitude comparator. It accepts two WIDTH-bit operands with a start handshake, scans them MSB-first one bit per clock, and reports greater-than, equal and less-than flags with a one-cycle done pulse. It supports signed and unsigned compares and an optional early exit. It generalises the team's combinational single-bit greater-than cell into a sequential, multi-bit, multi-mode block, and it serves as a fault-simulation target with real state.

---
 rtl/seq_cmp_mag.sv | 151 +++++++++++++++
 1 files changed

// File: rtl/seq_cmp_mag.sv
`default_nettype none
// ============================================================================
// Module      : seq_cmp_mag
// Description : Bit-serial MSB-first magnitude comparator. It latches two
//               WIDTH-bit operands on start, examines one bit per clock and
//               reports gt/eq/lt with a one-cycle done pulse. It supports
//               signed or unsigned compares and an optional early exit.
// Revision    : 1.0  initial release
// ============================================================================
module seq_cmp_mag #(
  parameter int WIDTH      = 8,
  parameter int EARLY_EXIT = 1
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic             signed_mode,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  output logic             ready,
  output logic             done,
  output logic             gt,
  output logic             eq,
  output logic             lt
);

  localparam int               IDX_W   = (WIDTH > 1) ? $clog2(WIDTH) : 1;
  localparam logic [IDX_W-1:0] IDX_MSB = IDX_W'(WIDTH - 1);
  localparam logic [IDX_W-1:0] IDX_ONE = IDX_W'(1);

  localparam logic [0:0] S_IDLE = 1'b0;
  localparam logic [0:0] S_RUN  = 1'b1;

  logic [0:0]       r_state;
  logic [0:0]       w_state_nxt;
  logic [IDX_W-1:0] r_idx;
  logic [WIDTH-1:0] r_a;
  logic [WIDTH-1:0] r_b;
  logic             r_signed;
  logic             r_decided;
  logic             r_gt_n;
  logic             r_lt_n;
  logic             r_done;
  logic             r_gt;
  logic             r_eq;
  logic             r_lt;

  logic             w_a_bit;
  logic             w_b_bit;
  logic             w_diff;
  logic             w_sign_bit;
  logic             w_last;
  logic             w_exit;
  logic             w_decided;
  logic             w_gt_n;
  logic             w_lt_n;
  logic             w_accept;
  logic             w_run_exit;

  // Per-bit evaluation of the current scan position.
  // The sign bit of a signed compare carries negative weight, so a 1 there
  // means "smaller" and the gt/lt sense flips. Once decided, the earlier
  // (more significant) verdict is kept.
  always_comb begin
    w_a_bit    = r_a[r_idx];
    w_b_bit    = r_b[r_idx];
    w_diff     = w_a_bit ^ w_b_bit;
    w_sign_bit = r_signed && (r_idx == IDX_MSB);
    w_last     = (r_idx == '0);
    w_decided  = r_decided | w_diff;
    w_gt_n     = r_decided ? r_gt_n : (w_diff & (w_sign_bit ? w_b_bit : w_a_bit));
    w_lt_n     = r_decided ? r_lt_n : (w_diff & (w_sign_bit ? w_a_bit : w_b_bit));
    w_exit     = (EARLY_EXIT != 0) ? (w_diff | w_last) : w_last;
  end

  // State register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= S_IDLE;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  // Next-state logic.
  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      S_IDLE:  if (start)  w_state_nxt = S_RUN;
      S_RUN:   if (w_exit) w_state_nxt = S_IDLE;
      default: w_state_nxt = S_IDLE;
    endcase
  end

  // FSM-derived control outputs.
  always_comb begin
    ready      = (r_state == S_IDLE);
    w_accept   = (r_state == S_IDLE) & start;
    w_run_exit = (r_state == S_RUN) & w_exit;
  end

  // Operand latch, scan index and sticky first-difference tracking.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_idx     <= IDX_MSB;
      r_a       <= '0;
      r_b       <= '0;
      r_signed  <= 1'b0;
      r_decided <= 1'b0;
      r_gt_n    <= 1'b0;
      r_lt_n    <= 1'b0;
    end else if (w_accept) begin
      r_idx     <= IDX_MSB;
      r_a       <= a;
      r_b       <= b;
      r_signed  <= signed_mode;
      r_decided <= 1'b0;
      r_gt_n    <= 1'b0;
      r_lt_n    <= 1'b0;
    end else if ((r_state == S_RUN) && !w_exit) begin
      r_idx     <= r_idx - IDX_ONE;
      r_decided <= w_decided;
      r_gt_n    <= w_gt_n;
      r_lt_n    <= w_lt_n;
    end
  end

  // Result flags load only on the exit edge and hold until the next one.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_done <= 1'b0;
      r_gt   <= 1'b0;
      r_eq   <= 1'b0;
      r_lt   <= 1'b0;
    end else begin
      r_done <= w_run_exit;
      if (w_run_exit) begin
        r_gt <= w_gt_n;
        r_lt <= w_lt_n;
        r_eq <= ~w_decided;
      end
    end
  end

  assign done = r_done;
  assign gt   = r_gt;
  assign eq   = r_eq;
  assign lt   = r_lt;

endmodule
`default_nettype wire
